// File: rtl/ras_rollback_ctrl.sv
// Call-stack rollback generator: carries per-instruction stack snapshots through DU/EXU and
// restores the stack on an EXU mispredict. Define RAS_RBK_STATS_EN to build the rollback counter.
`ifndef RAS_DPT
`define RAS_DPT 8
`endif

module ras_rollback_ctrl #(
    parameter  int ST_DPT  = `RAS_DPT,
    localparam int ST_PTRW = $clog2(ST_DPT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_stall,
    input  logic               i_fu_valid,
    input  logic               i_fu_is_call,
    input  logic               i_fu_ret_taken,
    input  logic [ST_PTRW-1:0] i_st_snap_ptr,
    input  logic               i_st_snap_full,
    input  logic               i_ras_flush,
    input  logic               i_exu_flush,
    output logic               o_st_rbk_en,
    output logic [ST_PTRW-1:0] o_st_rbk_ptr,
    output logic               o_st_rbk_full,
    output logic               o_st_rbk_incr_ptr,
    output logic               o_is_call_fu,
    output logic               o_is_call_du,
    output logic               o_is_ret_taken_du,
    output logic               o_busy,
    output logic [15:0]        o_rbk_cnt,
    output logic [1:0]         o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RBK   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state;
    logic [1:0]         drain_cnt;

    logic               du_valid, du_call, du_ret, du_full;
    logic [ST_PTRW-1:0] du_ptr;
    logic               exu_valid, exu_call, exu_full;
    logic [ST_PTRW-1:0] exu_ptr;

    logic               take_rbk;

    // Rollback interface: o_st_rbk_en is a one-cycle strobe with no back-pressure; ptr/full/incr_ptr
    // are meaningful only while it is high and otherwise hold their last values.
    assign take_rbk     = (state == S_IDLE) & i_exu_flush & exu_valid;
    assign o_is_call_fu = i_fu_valid & i_fu_is_call & ~i_ras_flush;
    assign o_is_call_du      = du_valid & du_call;
    assign o_is_ret_taken_du = du_valid & du_ret;
    assign o_dbg_state  = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_IDLE;
            drain_cnt         <= 2'd0;
            du_valid          <= 1'b0;
            du_call           <= 1'b0;
            du_ret            <= 1'b0;
            du_ptr            <= '0;
            du_full           <= 1'b0;
            exu_valid         <= 1'b0;
            exu_call          <= 1'b0;
            exu_ptr           <= '0;
            exu_full          <= 1'b0;
            o_st_rbk_en       <= 1'b0;
            o_st_rbk_ptr      <= '0;
            o_st_rbk_full     <= 1'b0;
            o_st_rbk_incr_ptr <= 1'b0;
            o_busy            <= 1'b0;
        end else begin
            o_st_rbk_en <= 1'b0;

            // A taken rollback kills everything in flight, including the FU capture, even under stall.
            if (take_rbk) begin
                du_valid  <= 1'b0;
                exu_valid <= 1'b0;
            end else if (!i_stall) begin
                du_valid  <= i_fu_valid & ~i_ras_flush;
                du_call   <= i_fu_is_call;
                du_ret    <= i_fu_ret_taken;
                du_ptr    <= i_st_snap_ptr;
                du_full   <= i_st_snap_full;
                exu_valid <= du_valid;
                exu_call  <= du_call;
                exu_ptr   <= du_ptr;
                exu_full  <= du_full;
            end

            case (state)
                S_IDLE: begin
                    if (take_rbk) begin
                        state             <= S_RBK;
                        o_st_rbk_en       <= 1'b1;
                        o_st_rbk_ptr      <= exu_ptr;
                        o_st_rbk_full     <= exu_full;
                        o_st_rbk_incr_ptr <= exu_call;
                        o_busy            <= 1'b1;
                    end
                end
                S_RBK: begin
                    drain_cnt <= 2'd2;
                    state     <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!i_stall) begin
                        drain_cnt <= drain_cnt - 2'd1;
                        if (drain_cnt == 2'd1) begin
                            state  <= S_IDLE;
                            o_busy <= 1'b0;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAS_RBK_STATS_EN
    logic [15:0] rbk_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rbk_cnt <= 16'h0;
        end else if (state == S_RBK && rbk_cnt != 16'hFFFF) begin
            rbk_cnt <= rbk_cnt + 16'd1;
        end
    end

    assign o_rbk_cnt = rbk_cnt;
`else
    assign o_rbk_cnt = 16'h0;
`endif

endmodule

// File: doc/ras_rollback_ctrl.md
# ras_rollback_ctrl

Generates the call-stack rollback request: the other end of the call stack's rollback interface. The block carries each instruction's stack snapshot (pointer, full flag, CALL / RET-taken flags) from the FU output through the DU and EXU stages. When EXU resolves a branch mispredict, it issues a single-cycle rollback that restores the call stack to that instruction's post-speculation state. It also drives the pipeline speculative-state flags consumed by the RAS predictor.

## Interface
- ST_DPT, `RAS_DPT (8): call stack depth; power of 2.
- ST_PTRW, $clog2(ST_DPT): localparam; pointer width.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- i_stall  in  1  pipeline stall; freezes DU/EXU snapshot registers.
- i_fu_valid  in  1  valid instruction at FU output.
- i_fu_is_call  in  1  FU-output instruction is CALL.
- i_fu_ret_taken  in  1  FU-output RET was RAS-predicted taken.
- i_st_snap_ptr  in  ST_PTRW  stack pointer snapshot, aligned with FU output.
- i_st_snap_full  in  1  stack full snapshot, aligned with FU output.
- i_ras_flush  in  1  RAS flush; FU-output instruction is killed.
- i_exu_flush  in  1  branch mispredict resolved for the EXU-stage instruction.
- o_st_rbk_en  out  1  rollback strobe.
- o_st_rbk_ptr  out  ST_PTRW  rollback pointer.
- o_st_rbk_full  out  1  rollback full state.
- o_st_rbk_incr_ptr  out  1  snapshot includes a speculative push (EXU instruction is CALL).
- o_is_call_fu  out  1  i_fu_valid & i_fu_is_call & ~i_ras_flush (combinational).
- o_is_call_du  out  1  DU-stage valid CALL.
- o_is_ret_taken_du  out  1  DU-stage valid RET-taken.
- o_busy  out  1  FSM not IDLE.
- o_rbk_cnt  out  16  rollback count (macro-dependent; see Configuration).

## Operation
- Snapshot entry: {valid, is_call, ret_taken, ptr, full}. There are two registered stages, DU and EXU.
- When i_stall=0:
  - DU loads the FU inputs; valid = i_fu_valid & ~i_ras_flush.
  - EXU loads DU.
- When i_stall=1, both stages hold.
- FSM states:
  - IDLE: i_exu_flush & exu.valid -> RBK. Latch exu.ptr/full/is_call into output registers. Clear DU and EXU valid (regardless of stall).
  - RBK: one cycle with o_st_rbk_en=1. Load the drain counter with 2, then -> DRAIN.
  - DRAIN: ignore i_exu_flush. Decrement the counter on each non-stalled cycle; at 0 -> IDLE. DU/EXU keep loading normally (the killed path refills).
- i_exu_flush with exu.valid=0, or in RBK/DRAIN: ignored.
- i_exu_flush together with i_ras_flush in the same cycle: the EXU flush wins. All stages are invalidated, including the FU capture.
- o_st_rbk_ptr/full/incr_ptr hold their last values outside RBK. Consumers qualify them with o_st_rbk_en.
- The pointer is passed through unmodified; wrap-around is the call stack's responsibility (modulo ST_DPT).

## Timing
- Reset (rst=1 at an edge): all outputs 0, FSM IDLE, stage valids 0, counter 0.
- Reset in RBK/DRAIN aborts the sequence; o_st_rbk_en is 0 from the next edge.
- Flush at edge T (sampled) -> o_st_rbk_en=1 during cycle T+1, exactly one cycle, even if i_stall=1.
- Snapshot latency is 1 cycle per stage: FU -> DU at +1, DU -> EXU at +2 non-stalled cycles.
- o_is_call_du and o_is_ret_taken_du are registered outputs. They deassert the cycle after a flush.

## Configuration
- RAS_RBK_STATS_EN defined: o_rbk_cnt increments by 1 on every RBK cycle and saturates at 16'hFFFF. It is cleared by rst.
- RAS_RBK_STATS_EN undefined: o_rbk_cnt is tied to 0 and no counter logic is built.

## Test plan
- Reset: assert rst for 2 cycles with i_exu_flush=1 -> all outputs 0 and o_busy=0.
- Snapshot pipe: FU CALL with ptr=3, full=0; two cycles later i_exu_flush=1 -> next cycle o_st_rbk_en=1, ptr=3, full=0, incr_ptr=1, o_busy=1 for 1+2 cycles.
- Stall: i_stall=1 for 3 cycles after capturing ptr=5 at DU -> EXU snapshot appears only after the stall ends. A flush during stall still produces a 1-cycle strobe.
- Wrap and full: with ST_DPT=8, FU RET-taken with ptr=7, full=1 reaches EXU and flushes -> ptr=7, full=1, incr_ptr=0.
- Simultaneous: i_exu_flush=1 and i_ras_flush=1 -> one strobe, o_is_call_du=0 next cycle, a second flush in DRAIN is ignored.
- Stats (macro on): 3 separated rollbacks -> o_rbk_cnt=3; macro off -> o_rbk_cnt=0.
